// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vga_pkg
// Brief    : Shared 640x480@60 raster timing constants and helpers.
// Revision : 1.0
// ============================================================================
package vga_pkg;

  localparam int CNT_W = 10;

  typedef logic [CNT_W-1:0] coord_t;

  localparam int CLK_DIV_DEF   = 2;
  localparam int H_DISPLAY_DEF = 640;
  localparam int H_FRONT_DEF   = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BACK_DEF    = 48;
  localparam int V_DISPLAY_DEF = 480;
  localparam int V_FRONT_DEF   = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BACK_DEF    = 33;
  localparam bit SYNC_POL_DEF  = 1'b0;

  // Maps an "in sync window" flag onto the physical pin level.
  function automatic logic sync_level(input logic active, input logic pol);
    return active ? pol : ~pol;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_timing_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen_if
// Brief    : Raster timing bundle from the timing generator to pixel consumers.
// Revision : 1.0
// ============================================================================
interface vga_timing_gen_if;
  import vga_pkg::*;

  logic   pixel_tick;
  logic   hsync;
  logic   vsync;
  logic   display_on;
  logic   frame_start;
  coord_t pixel_x;
  coord_t pixel_y;

  modport master (
    output pixel_tick, hsync, vsync, display_on, frame_start, pixel_x, pixel_y
  );

  modport slave (
    input pixel_tick, hsync, vsync, display_on, frame_start, pixel_x, pixel_y
  );

endinterface
`default_nettype wire

// File: rtl/vga_tick_div.sv
`default_nettype none
// ============================================================================
// Module   : vga_tick_div
// Brief    : Divides the system clock into a one-cycle pixel-rate enable.
// Revision : 1.0
// ============================================================================
module vga_tick_div #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  output logic pixel_tick
);

  // A 1-bit counter that never leaves 0 covers CLK_DIV=1 without a special case.
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  if (CLK_DIV < 1) begin : g_bad_div
    $error("vga_tick_div: CLK_DIV must be >= 1");
  end

  logic [DIV_W-1:0] div_cnt_q;
  logic [DIV_W-1:0] div_cnt_d;

  always_comb begin
    div_cnt_d = div_cnt_q + DIV_W'(1);
    if (div_cnt_q >= DIV_LAST) begin
      div_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

  assign pixel_tick = (div_cnt_q == DIV_LAST);

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen
// Brief    : Raster counters and registered hsync/vsync/display_on/frame_start.
// Revision : 1.0
// ============================================================================
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int CLK_DIV   = CLK_DIV_DEF,
  parameter int H_DISPLAY = H_DISPLAY_DEF,
  parameter int H_FRONT   = H_FRONT_DEF,
  parameter int H_SYNC    = H_SYNC_DEF,
  parameter int H_BACK    = H_BACK_DEF,
  parameter int V_DISPLAY = V_DISPLAY_DEF,
  parameter int V_FRONT   = V_FRONT_DEF,
  parameter int V_SYNC    = V_SYNC_DEF,
  parameter int V_BACK    = V_BACK_DEF,
  parameter bit SYNC_POL  = SYNC_POL_DEF
) (
  input  logic              clk,
  input  logic              reset,
  vga_timing_gen_if.master  vga
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam coord_t H_LAST   = coord_t'(H_TOTAL - 1);
  localparam coord_t V_LAST   = coord_t'(V_TOTAL - 1);
  localparam coord_t H_VIS    = coord_t'(H_DISPLAY);
  localparam coord_t V_VIS    = coord_t'(V_DISPLAY);
  localparam coord_t HS_START = coord_t'(H_DISPLAY + H_FRONT);
  localparam coord_t HS_END   = coord_t'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam coord_t VS_START = coord_t'(V_DISPLAY + V_FRONT);
  localparam coord_t VS_END   = coord_t'(V_DISPLAY + V_FRONT + V_SYNC);

  if (H_TOTAL > (1 << CNT_W) || V_TOTAL > (1 << CNT_W)) begin : g_bad_total
    $error("vga_timing_gen: H_TOTAL and V_TOTAL must fit the 10-bit counters");
  end

  logic   pixel_tick;
  coord_t h_q, h_d;
  coord_t v_q, v_d;
  logic   hsync_q, hsync_d;
  logic   vsync_q, vsync_d;
  logic   display_on_q, display_on_d;
  logic   frame_start_q, frame_start_d;

  vga_tick_div #(
    .CLK_DIV (CLK_DIV)
  ) u_tick_div (
    .clk        (clk),
    .reset      (reset),
    .pixel_tick (pixel_tick)
  );

  always_comb begin
    h_d           = h_q;
    v_d           = v_q;
    frame_start_d = 1'b0;
    if (pixel_tick) begin
      // >= rather than == so a corrupted count still wraps back into range.
      if (h_q >= H_LAST) begin
        h_d = '0;
        v_d = (v_q >= V_LAST) ? '0 : v_q + coord_t'(1);
      end else begin
        h_d = h_q + coord_t'(1);
      end
      frame_start_d = (h_d == '0) && (v_d == '0);
    end
    // Decoded from the next counts so the flops line up with pixel_x/pixel_y.
    hsync_d      = sync_level((h_d >= HS_START) && (h_d < HS_END), SYNC_POL);
    vsync_d      = sync_level((v_d >= VS_START) && (v_d < VS_END), SYNC_POL);
    display_on_d = (h_d < H_VIS) && (v_d < V_VIS);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      h_q           <= H_LAST;
      v_q           <= V_LAST;
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      display_on_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      h_q           <= h_d;
      v_q           <= v_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      display_on_q  <= display_on_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign vga.pixel_tick  = pixel_tick;
  assign vga.pixel_x     = h_q;
  assign vga.pixel_y     = v_q;
  assign vga.hsync       = hsync_q;
  assign vga.vsync       = vsync_q;
  assign vga.display_on  = display_on_q;
  assign vga.frame_start = frame_start_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_timing_gen
// Brief    : Scoreboard bench for vga_timing_gen on a shrunken raster.
// Revision : 1.0
// ============================================================================
module tb_vga_timing_gen;
  import vga_pkg::*;

  localparam int HD = 16, HF = 4, HS = 6, HB = 6, HT = HD + HF + HS + HB;
  localparam int VD = 12, VF = 3, VS = 2, VB = 4, VT = VD + VF + VS + VB;
  localparam int FT = HT * VT;

  typedef struct packed {
    logic       tick;
    logic       hs;
    logic       vs;
    logic       disp;
    logic       fs;
    logic [9:0] x;
    logic [9:0] y;
  } obs_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  vga_timing_gen_if if_a();
  vga_timing_gen_if if_b();

  vga_timing_gen #(
    .CLK_DIV(2), .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .SYNC_POL(1'b0)
  ) dut_a (.clk(clk), .reset(reset), .vga(if_a));

  vga_timing_gen #(
    .CLK_DIV(1), .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .SYNC_POL(1'b1)
  ) dut_b (.clk(clk), .reset(reset), .vga(if_b));

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  obs_t sb_a[$];
  obs_t sb_b[$];
  int   last_fs_a = -1, last_fs_b = -1;
  int   hs_run_a = 0, hs_run_b = 0, vs_run_a = 0;

  // Position derived from the number of pixel ticks since reset release.
  function automatic obs_t model(int c, int d, bit pol);
    obs_t e;
    int   n;
    int   pos;
    n      = c / d;
    e.tick = ((c % d) == d - 1);
    if (n == 0) begin
      e.x  = 10'(HT - 1);
      e.y  = 10'(VT - 1);
      e.fs = 1'b0;
    end else begin
      pos  = (n - 1) % FT;
      e.x  = 10'(pos % HT);
      e.y  = 10'(pos / HT);
      e.fs = ((c % d) == 0) && (pos == 0);
    end
    e.hs   = ((int'(e.x) >= HD + HF) && (int'(e.x) < HD + HF + HS)) ? pol : ~pol;
    e.vs   = ((int'(e.y) >= VD + VF) && (int'(e.y) < VD + VF + VS)) ? pol : ~pol;
    e.disp = (int'(e.x) < HD) && (int'(e.y) < VD);
    return e;
  endfunction

  function automatic obs_t sample_a();
    obs_t o;
    o.tick = if_a.pixel_tick; o.hs = if_a.hsync; o.vs = if_a.vsync;
    o.disp = if_a.display_on; o.fs = if_a.frame_start;
    o.x = if_a.pixel_x; o.y = if_a.pixel_y;
    return o;
  endfunction

  function automatic obs_t sample_b();
    obs_t o;
    o.tick = if_b.pixel_tick; o.hs = if_b.hsync; o.vs = if_b.vsync;
    o.disp = if_b.display_on; o.fs = if_b.frame_start;
    o.x = if_b.pixel_x; o.y = if_b.pixel_y;
    return o;
  endfunction

  task automatic check(input string tag, input obs_t o, input obs_t e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed tick=%0b hs=%0b vs=%0b disp=%0b fs=%0b x=%0d y=%0d expected tick=%0b hs=%0b vs=%0b disp=%0b fs=%0b x=%0d y=%0d",
             tag, cyc, o.tick, o.hs, o.vs, o.disp, o.fs, o.x, o.y,
             e.tick, e.hs, e.vs, e.disp, e.fs, e.x, e.y);
    end
  endtask

  task automatic check_int(input string tag, input int o, input int e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, o, e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (reset) cyc++;
    else       cyc = 0;
    sb_a.push_back(model(cyc, 2, 1'b0));
    sb_b.push_back(model(cyc, 1, 1'b1));
    #1;
    check("raster_a", sample_a(), sb_a.pop_front());
    check("raster_b", sample_b(), sb_b.pop_front());
    if (if_a.frame_start) begin
      if (last_fs_a >= 0) check_int("frame_period_a", cyc - last_fs_a, FT * 2);
      last_fs_a = cyc;
    end
    if (if_b.frame_start) begin
      if (last_fs_b >= 0) check_int("frame_period_b", cyc - last_fs_b, FT);
      last_fs_b = cyc;
    end
    if (if_a.hsync == 1'b0) hs_run_a++;
    else if (hs_run_a > 0) begin
      check_int("hsync_width_a", hs_run_a, HS * 2);
      hs_run_a = 0;
    end
    if (if_b.hsync == 1'b1) hs_run_b++;
    else if (hs_run_b > 0) begin
      check_int("hsync_width_b", hs_run_b, HS);
      hs_run_b = 0;
    end
    if (if_a.vsync == 1'b0) vs_run_a++;
    else if (vs_run_a > 0) begin
      check_int("vsync_width_a", vs_run_a, VS * HT * 2);
      vs_run_a = 0;
    end
  endtask

  initial begin
    obs_t e;
    bit   found;

    reset = 1'b0;
    repeat (3) step();
    @(negedge clk) reset = 1'b1;
    repeat (2 * FT * 2 + 8) step();

    // Walk into the corner where both syncs are active, then reset mid-pulse.
    found = 1'b0;
    for (int i = 0; i < FT * 2 + 4 && !found; i++) begin
      step();
      e = model(cyc, 2, 1'b0);
      found = (int'(e.x) >= HD + HF) && (int'(e.x) < HD + HF + HS) &&
              (int'(e.y) >= VD + VF) && (int'(e.y) < VD + VF + VS);
    end
    check_int("sync_corner_reached", int'(found), 1);
    check_int("pre_reset_syncs_a", int'({if_a.hsync, if_a.vsync}), 0);

    #2 reset = 1'b0;
    #1;
    cyc = 0;
    last_fs_a = -1; last_fs_b = -1;
    hs_run_a = 0; hs_run_b = 0; vs_run_a = 0;
    check("async_reset_a", sample_a(), model(0, 2, 1'b0));
    check("async_reset_b", sample_b(), model(0, 1, 1'b1));

    repeat (2) step();
    @(negedge clk) reset = 1'b1;
    repeat (FT * 2 + 8) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
